cache_mem_arbiter: RTL

- Shares the single 32-bit simple-AXI memory port between two cache masters: m0 = icache, m1 = dcache.
- Each cache issues line fills and writebacks as BEATS separate address handshakes plus BEATS data beats.
- The arbiter locks a grant for a whole burst, then round-robins between the masters.
- Read and write channels are arbitrated independently and run concurrently; it sits between the caches and the memory/SoC bus bridge.

---
 rtl/cache_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one simple-AXI memory port between the instruction cache
//             (m0) and the data cache (m1). Read and write channels each have
//             their own arbiter. A grant is held for a whole burst of BEATS
//             address handshakes and BEATS data beats. On the write channel a
//             burst also covers BEATS responses. Masters alternate between
//             bursts when both are requesting.
//  Ports    : clk, rst_n (synchronous, active-low)
//             m0_*/m1_*  : cache-side read address/data, write address/data,
//                          and write response channels
//             s_*        : memory-side mirror of the same channels
//             rd_busy/rd_grant, wr_busy/wr_grant : burst status per channel
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int BEATS = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // master 0 (icache)
    input  logic          m0_ravalid,
    input  logic [AW-1:0] m0_raaddr,
    output logic          m0_raready,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m0_rready,
    input  logic          m0_wavalid,
    input  logic [AW-1:0] m0_waaddr,
    output logic          m0_waready,
    input  logic          m0_wvalid,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_wready,
    output logic          m0_bvalid,
    output logic [1:0]    m0_bresp,
    input  logic          m0_bready,
    // master 1 (dcache)
    input  logic          m1_ravalid,
    input  logic [AW-1:0] m1_raaddr,
    output logic          m1_raready,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    input  logic          m1_rready,
    input  logic          m1_wavalid,
    input  logic [AW-1:0] m1_waaddr,
    output logic          m1_waready,
    input  logic          m1_wvalid,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_wready,
    output logic          m1_bvalid,
    output logic [1:0]    m1_bresp,
    input  logic          m1_bready,
    // memory side
    output logic          s_ravalid,
    output logic [AW-1:0] s_raaddr,
    input  logic          s_raready,
    input  logic          s_rvalid,
    input  logic [DW-1:0] s_rdata,
    output logic          s_rready,
    output logic          s_wavalid,
    output logic [AW-1:0] s_waaddr,
    input  logic          s_waready,
    output logic          s_wvalid,
    output logic [DW-1:0] s_wdata,
    input  logic          s_wready,
    input  logic          s_bvalid,
    input  logic [1:0]    s_bresp,
    output logic          s_bready,
    // status
    output logic          rd_busy,
    output logic          rd_grant,
    output logic          wr_busy,
    output logic          wr_grant
);

    localparam int            CW      = $clog2(BEATS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BEATS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    logic [0:0]    rd_state_q, rd_state_d;
    logic          rd_grant_q, rd_grant_d;
    logic          rd_last_q,  rd_last_d;
    logic [CW-1:0] ar_cnt_q,   ar_cnt_d;
    logic [CW-1:0] r_cnt_q,    r_cnt_d;

    logic          rd_active;
    logic          ar_open;
    logic          r_open;
    logic          sel_ravalid;
    logic [AW-1:0] sel_raaddr;
    logic          sel_rready;

    assign rd_active   = (rd_state_q == ST_BUSY);
    // A counter at BEATS closes its channel so extra beats stall until re-arbitration.
    assign ar_open     = rd_active && (ar_cnt_q < CNT_MAX);
    assign r_open      = rd_active && (r_cnt_q  < CNT_MAX);

    assign sel_ravalid = rd_grant_q ? m1_ravalid : m0_ravalid;
    assign sel_raaddr  = rd_grant_q ? m1_raaddr  : m0_raaddr;
    assign sel_rready  = rd_grant_q ? m1_rready  : m0_rready;

    assign s_ravalid   = ar_open && sel_ravalid;
    assign s_raaddr    = rd_active ? sel_raaddr : '0;
    assign s_rready    = r_open && sel_rready;

    assign m0_raready  = ar_open && !rd_grant_q && s_raready;
    assign m1_raready  = ar_open &&  rd_grant_q && s_raready;
    assign m0_rvalid   = r_open  && !rd_grant_q && s_rvalid;
    assign m1_rvalid   = r_open  &&  rd_grant_q && s_rvalid;
    assign m0_rdata    = (rd_active && !rd_grant_q) ? s_rdata : '0;
    assign m1_rdata    = (rd_active &&  rd_grant_q) ? s_rdata : '0;

    assign rd_busy     = rd_active;
    assign rd_grant    = rd_grant_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_last_d  = rd_last_q;
        ar_cnt_d   = ar_cnt_q;
        r_cnt_d    = r_cnt_q;
        if (rd_state_q == ST_IDLE) begin
            if (m0_ravalid || m1_ravalid) begin
                rd_state_d = ST_BUSY;
                // On contention the master that did not own the last burst wins.
                rd_grant_d = (m0_ravalid && m1_ravalid) ? !rd_last_q : m1_ravalid;
            end
        end else begin
            if (s_ravalid && s_raready) ar_cnt_d = ar_cnt_q + CNT_ONE;
            if (s_rvalid  && s_rready)  r_cnt_d  = r_cnt_q  + CNT_ONE;
            if ((ar_cnt_d == CNT_MAX) && (r_cnt_d == CNT_MAX)) begin
                rd_state_d = ST_IDLE;
                rd_last_d  = rd_grant_q;
                ar_cnt_d   = '0;
                r_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= ST_IDLE;
            rd_grant_q <= 1'b0;
            rd_last_q  <= 1'b1;
            ar_cnt_q   <= '0;
            r_cnt_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_last_q  <= rd_last_d;
            ar_cnt_q   <= ar_cnt_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------
    logic [0:0]    wr_state_q, wr_state_d;
    logic          wr_grant_q, wr_grant_d;
    logic          wr_last_q,  wr_last_d;
    logic [CW-1:0] aw_cnt_q,   aw_cnt_d;
    logic [CW-1:0] w_cnt_q,    w_cnt_d;
    logic [CW-1:0] b_cnt_q,    b_cnt_d;

    logic          wr_active;
    logic          aw_open;
    logic          w_open;
    logic          b_open;
    logic          sel_wavalid;
    logic [AW-1:0] sel_waaddr;
    logic          sel_wvalid;
    logic [DW-1:0] sel_wdata;
    logic          sel_bready;

    assign wr_active   = (wr_state_q == ST_BUSY);
    assign aw_open     = wr_active && (aw_cnt_q < CNT_MAX);
    assign w_open      = wr_active && (w_cnt_q  < CNT_MAX);
    assign b_open      = wr_active && (b_cnt_q  < CNT_MAX);

    assign sel_wavalid = wr_grant_q ? m1_wavalid : m0_wavalid;
    assign sel_waaddr  = wr_grant_q ? m1_waaddr  : m0_waaddr;
    assign sel_wvalid  = wr_grant_q ? m1_wvalid  : m0_wvalid;
    assign sel_wdata   = wr_grant_q ? m1_wdata   : m0_wdata;
    assign sel_bready  = wr_grant_q ? m1_bready  : m0_bready;

    assign s_wavalid   = aw_open && sel_wavalid;
    assign s_waaddr    = wr_active ? sel_waaddr : '0;
    assign s_wvalid    = w_open && sel_wvalid;
    assign s_wdata     = wr_active ? sel_wdata : '0;
    assign s_bready    = b_open && sel_bready;

    assign m0_waready  = aw_open && !wr_grant_q && s_waready;
    assign m1_waready  = aw_open &&  wr_grant_q && s_waready;
    assign m0_wready   = w_open  && !wr_grant_q && s_wready;
    assign m1_wready   = w_open  &&  wr_grant_q && s_wready;
    assign m0_bvalid   = b_open  && !wr_grant_q && s_bvalid;
    assign m1_bvalid   = b_open  &&  wr_grant_q && s_bvalid;
    assign m0_bresp    = (wr_active && !wr_grant_q) ? s_bresp : 2'b00;
    assign m1_bresp    = (wr_active &&  wr_grant_q) ? s_bresp : 2'b00;

    assign wr_busy     = wr_active;
    assign wr_grant    = wr_grant_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_last_d  = wr_last_q;
        aw_cnt_d   = aw_cnt_q;
        w_cnt_d    = w_cnt_q;
        b_cnt_d    = b_cnt_q;
        if (wr_state_q == ST_IDLE) begin
            if (m0_wavalid || m1_wavalid) begin
                wr_state_d = ST_BUSY;
                wr_grant_d = (m0_wavalid && m1_wavalid) ? !wr_last_q : m1_wavalid;
            end
        end else begin
            if (s_wavalid && s_waready) aw_cnt_d = aw_cnt_q + CNT_ONE;
            if (s_wvalid  && s_wready)  w_cnt_d  = w_cnt_q  + CNT_ONE;
            if (s_bvalid  && s_bready)  b_cnt_d  = b_cnt_q  + CNT_ONE;
            if ((aw_cnt_d == CNT_MAX) && (w_cnt_d == CNT_MAX) && (b_cnt_d == CNT_MAX)) begin
                wr_state_d = ST_IDLE;
                wr_last_d  = wr_grant_q;
                aw_cnt_d   = '0;
                w_cnt_d    = '0;
                b_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= ST_IDLE;
            wr_grant_q <= 1'b0;
            wr_last_q  <= 1'b1;
            aw_cnt_q   <= '0;
            w_cnt_q    <= '0;
            b_cnt_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_last_q  <= wr_last_d;
            aw_cnt_q   <= aw_cnt_d;
            w_cnt_q    <= w_cnt_d;
            b_cnt_q    <= b_cnt_d;
        end
    end

endmodule
`default_nettype wire
